placement_cost_eval: RTL and testbench

//  Downstream stage of the random placer. Once placement completes, walks the edge list
//  (EA/EB ROMs) and fetches both endpoint positions from the pos_X/pos_Y RAMs. Accumulates

---
 rtl/placement_cost_eval_if.sv | 48 ++++
 rtl/placement_cost_eval.sv | 213 +++++++++++++++++++++
 tb/tb_placement_cost_eval.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/placement_cost_eval_if.sv
// Control, memory-port and result bundle for placement_cost_eval. The max_len/max_edge
// signals exist only when EVAL_CRITICAL_EN is defined.
interface placement_cost_eval_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          start;
  logic          busy;
  logic          done;
  logic          edge_re;
  logic [AW-1:0] edge_addr;
  logic [DW-1:0] edge_a;
  logic [DW-1:0] edge_b;
  logic          pos_re;
  logic [AW-1:0] pos_addr;
  logic [DW-1:0] pos_x;
  logic [DW-1:0] pos_y;
  logic [31:0]   sum;
  logic [31:0]   sum_1hop;
  logic [15:0]   unplaced_cnt;
  logic [31:0]   cycles;
`ifdef EVAL_CRITICAL_EN
  logic [31:0]   max_len;
  logic [AW-1:0] max_edge;

  modport master (
    input  start, edge_a, edge_b, pos_x, pos_y,
    output busy, done, edge_re, edge_addr, pos_re, pos_addr,
           sum, sum_1hop, unplaced_cnt, cycles, max_len, max_edge
  );
  modport slave (
    output start, edge_a, edge_b, pos_x, pos_y,
    input  busy, done, edge_re, edge_addr, pos_re, pos_addr,
           sum, sum_1hop, unplaced_cnt, cycles, max_len, max_edge
  );
`else
  modport master (
    input  start, edge_a, edge_b, pos_x, pos_y,
    output busy, done, edge_re, edge_addr, pos_re, pos_addr,
           sum, sum_1hop, unplaced_cnt, cycles
  );
  modport slave (
    output start, edge_a, edge_b, pos_x, pos_y,
    input  busy, done, edge_re, edge_addr, pos_re, pos_addr,
           sum, sum_1hop, unplaced_cnt, cycles
  );
`endif
endinterface

// File: rtl/placement_cost_eval.sv
// Walks the EA/EB edge list, fetches both endpoint positions and accumulates Manhattan and
// 1-hop cost plus an unplaced-edge count. Define EVAL_CRITICAL_EN for longest-edge tracking.
module placement_cost_eval #(
  parameter int N_EDGE = 22,
  parameter int AW     = 32,
  parameter int DW     = 32
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  placement_cost_eval_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, RD_EDGE, WT_EDGE, RD_A, WT_A, RD_B, WT_B, ACC, FIN
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        i_q, i_d;
  logic [DW-1:0]        b_q, b_d;
  logic signed [DW-1:0] xa_q, xa_d, ya_q, ya_d, xb_q, xb_d, yb_q, yb_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 edge_re_q, edge_re_d, pos_re_q, pos_re_d;
  logic [AW-1:0]        edge_addr_q, edge_addr_d, pos_addr_q, pos_addr_d;
  logic [31:0]          sum_q, sum_d, hop_q, hop_d, cyc_q, cyc_d;
  logic [15:0]          unpl_q, unpl_d;
`ifdef EVAL_CRITICAL_EN
  logic [31:0]          max_len_q, max_len_d;
  logic [AW-1:0]        max_edge_q, max_edge_d;
`endif

  function automatic logic [31:0] abs_diff(input logic signed [DW-1:0] p,
                                           input logic signed [DW-1:0] q);
    logic signed [31:0] d;
    d = 32'(p) - 32'(q);
    return d[31] ? 32'(-d) : 32'(d);
  endfunction

  function automatic logic [31:0] half_ceil(input logic [31:0] v);
    return (v >> 1) + {31'd0, v[0]};
  endfunction

  logic [31:0] dx_w, dy_w, len_w, hop_w;
  logic        placed_w;
  logic [AW-1:0] i_next_w;

  assign dx_w     = abs_diff(xa_q, xb_q);
  assign dy_w     = abs_diff(ya_q, yb_q);
  assign len_w    = dx_w + dy_w;
  assign hop_w    = half_ceil(dx_w) + half_ceil(dy_w) - 32'd1;
  assign placed_w = !(xa_q[DW-1] | ya_q[DW-1] | xb_q[DW-1] | yb_q[DW-1]);
  assign i_next_w = i_q + AW'(1);

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    b_d         = b_q;
    xa_d        = xa_q;
    ya_d        = ya_q;
    xb_d        = xb_q;
    yb_d        = yb_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    edge_re_d   = 1'b0;
    pos_re_d    = 1'b0;
    edge_addr_d = edge_addr_q;
    pos_addr_d  = pos_addr_q;
    sum_d       = sum_q;
    hop_d       = hop_q;
    unpl_d      = unpl_q;
    cyc_d       = busy_q ? cyc_q + 32'd1 : cyc_q;
`ifdef EVAL_CRITICAL_EN
    max_len_d   = max_len_q;
    max_edge_d  = max_edge_q;
`endif

    // Strobes and addresses are set on entry to the RD_* states so they are registered.
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sum_d  = '0;
          hop_d  = '0;
          unpl_d = '0;
          cyc_d  = '0;
          i_d    = '0;
          busy_d = 1'b1;
`ifdef EVAL_CRITICAL_EN
          max_len_d  = '0;
          max_edge_d = '0;
`endif
          if (N_EDGE == 0) begin
            state_d = FIN;
          end else begin
            state_d     = RD_EDGE;
            edge_re_d   = 1'b1;
            edge_addr_d = '0;
          end
        end
      end
      RD_EDGE: state_d = WT_EDGE;
      WT_EDGE: begin
        b_d        = bus.edge_b;
        pos_re_d   = 1'b1;
        pos_addr_d = AW'(bus.edge_a);
        state_d    = RD_A;
      end
      RD_A: state_d = WT_A;
      WT_A: begin
        xa_d       = bus.pos_x;
        ya_d       = bus.pos_y;
        pos_re_d   = 1'b1;
        pos_addr_d = AW'(b_q);
        state_d    = RD_B;
      end
      RD_B: state_d = WT_B;
      WT_B: begin
        xb_d    = bus.pos_x;
        yb_d    = bus.pos_y;
        state_d = ACC;
      end
      ACC: begin
        if (!placed_w) begin
          if (unpl_q != 16'hFFFF) unpl_d = unpl_q + 16'd1;
        end else begin
          sum_d = sum_q + len_w - 32'd1;
          hop_d = hop_q + hop_w;
`ifdef EVAL_CRITICAL_EN
          // Strict compare keeps the earliest edge on a tie.
          if (len_w > max_len_q) begin
            max_len_d  = len_w;
            max_edge_d = i_q;
          end
`endif
        end
        i_d = i_next_w;
        if (i_next_w == AW'(N_EDGE)) begin
          state_d = FIN;
        end else begin
          state_d     = RD_EDGE;
          edge_re_d   = 1'b1;
          edge_addr_d = i_next_w;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      i_q         <= '0;
      b_q         <= '0;
      xa_q        <= '0;
      ya_q        <= '0;
      xb_q        <= '0;
      yb_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      edge_re_q   <= 1'b0;
      pos_re_q    <= 1'b0;
      edge_addr_q <= '0;
      pos_addr_q  <= '0;
      sum_q       <= '0;
      hop_q       <= '0;
      unpl_q      <= '0;
      cyc_q       <= '0;
`ifdef EVAL_CRITICAL_EN
      max_len_q   <= '0;
      max_edge_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      b_q         <= b_d;
      xa_q        <= xa_d;
      ya_q        <= ya_d;
      xb_q        <= xb_d;
      yb_q        <= yb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      edge_re_q   <= edge_re_d;
      pos_re_q    <= pos_re_d;
      edge_addr_q <= edge_addr_d;
      pos_addr_q  <= pos_addr_d;
      sum_q       <= sum_d;
      hop_q       <= hop_d;
      unpl_q      <= unpl_d;
      cyc_q       <= cyc_d;
`ifdef EVAL_CRITICAL_EN
      max_len_q   <= max_len_d;
      max_edge_q  <= max_edge_d;
`endif
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.edge_re      = edge_re_q;
  assign bus.edge_addr    = edge_addr_q;
  assign bus.pos_re       = pos_re_q;
  assign bus.pos_addr     = pos_addr_q;
  assign bus.sum          = sum_q;
  assign bus.sum_1hop     = hop_q;
  assign bus.unplaced_cnt = unpl_q;
  assign bus.cycles       = cyc_q;
`ifdef EVAL_CRITICAL_EN
  assign bus.max_len      = max_len_q;
  assign bus.max_edge     = max_edge_q;
`endif
endmodule

// File: tb/tb_placement_cost_eval.sv
// Scoreboard bench for placement_cost_eval: a 22-edge instance driven with random and
// directed memory images, plus a 2-edge instance for the short worked example.
module tb_placement_cost_eval;
  localparam int NE = 22;

  typedef struct {
    int sum; int hop; int cnt; int cyc; int mlen; int medge;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  int ea_m[NE], eb_m[NE], px_m[16], py_m[16];
  int ea_s[2],  eb_s[2],  px_s[4],  py_s[4];
  exp_t q_m[$], q_s[$];

  always #5 clk = ~clk;

  placement_cost_eval_if #(.AW(32), .DW(32)) m ();
  placement_cost_eval_if #(.AW(32), .DW(32)) s ();

  placement_cost_eval #(.N_EDGE(NE), .AW(32), .DW(32)) dut_m (
    .clk_i(clk), .rst_ni(rst_n), .bus(m.master));
  placement_cost_eval #(.N_EDGE(2), .AW(32), .DW(32)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .bus(s.master));

  // Synchronous-read memories: data appears the cycle after the strobe and then holds.
  always @(posedge clk) begin
    if (m.edge_re) begin
      m.edge_a <= 32'(ea_m[m.edge_addr < NE ? int'(m.edge_addr) : 0]);
      m.edge_b <= 32'(eb_m[m.edge_addr < NE ? int'(m.edge_addr) : 0]);
    end
    if (m.pos_re) begin
      m.pos_x <= 32'(px_m[m.pos_addr[3:0]]);
      m.pos_y <= 32'(py_m[m.pos_addr[3:0]]);
    end
    if (s.edge_re) begin
      s.edge_a <= 32'(ea_s[s.edge_addr[0]]);
      s.edge_b <= 32'(eb_s[s.edge_addr[0]]);
    end
    if (s.pos_re) begin
      s.pos_x <= 32'(px_s[s.pos_addr[1:0]]);
      s.pos_y <= 32'(py_s[s.pos_addr[1:0]]);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, $signed(act), $signed(exp));
    end
  endtask

  // Reference: sum over edges of Manhattan length - 1 and ceil-halved length - 1.
  function automatic exp_t model_main();
    exp_t r;
    int a, b, dx, dy;
    r = '{sum: 0, hop: 0, cnt: 0, cyc: 7 * NE + 1, mlen: 0, medge: 0};
    for (int e = 0; e < NE; e++) begin
      a = ea_m[e];
      b = eb_m[e];
      if (px_m[a] < 0 || py_m[a] < 0 || px_m[b] < 0 || py_m[b] < 0) begin
        r.cnt++;
      end else begin
        dx = (px_m[a] > px_m[b]) ? px_m[a] - px_m[b] : px_m[b] - px_m[a];
        dy = (py_m[a] > py_m[b]) ? py_m[a] - py_m[b] : py_m[b] - py_m[a];
        r.sum += dx + dy - 1;
        r.hop += (dx + 1) / 2 + (dy + 1) / 2 - 1;
        if (dx + dy > r.mlen) begin
          r.mlen  = dx + dy;
          r.medge = e;
        end
      end
    end
    return r;
  endfunction

  task automatic fill_random(input int pct);
    for (int n = 0; n < 16; n++) begin
      px_m[n] = ($urandom_range(99) < pct) ? -1 : int'($urandom_range(63));
      py_m[n] = ($urandom_range(99) < pct) ? -1 : int'($urandom_range(63));
    end
    for (int e = 0; e < NE; e++) begin
      ea_m[e] = int'($urandom_range(15));
      eb_m[e] = int'($urandom_range(15));
    end
  endtask

  task automatic start_main(input exp_t e);
    @(negedge clk);
    m.start = 1'b1;
    q_m.push_back(e);
    @(negedge clk);
    m.start = 1'b0;
  endtask

  task automatic wait_main(input string nm);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (q_m.size() == 0) return;
    end
    chk({nm, "_timeout"}, 32'd0, 32'd1);
    q_m.delete();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"},  32'(m.busy), 0);
    chk({nm, "_done"},  32'(m.done), 0);
    chk({nm, "_ere"},   32'(m.edge_re), 0);
    chk({nm, "_eaddr"}, m.edge_addr, 0);
    chk({nm, "_pre"},   32'(m.pos_re), 0);
    chk({nm, "_paddr"}, m.pos_addr, 0);
    chk({nm, "_sum"},   m.sum, 0);
    chk({nm, "_hop"},   m.sum_1hop, 0);
    chk({nm, "_unpl"},  32'(m.unplaced_cnt), 0);
    chk({nm, "_cyc"},   m.cycles, 0);
`ifdef EVAL_CRITICAL_EN
    chk({nm, "_mlen"},  m.max_len, 0);
    chk({nm, "_medge"}, m.max_edge, 0);
`endif
  endtask

  task automatic cmp_result(input string nm, input exp_t e, input logic [31:0] sm,
                            input logic [31:0] hp, input logic [15:0] uc,
                            input logic [31:0] cy);
    chk({nm, "_sum"},  sm, 32'(e.sum));
    chk({nm, "_hop"},  hp, 32'(e.hop));
    chk({nm, "_unpl"}, 32'(uc), 32'(e.cnt));
    chk({nm, "_cyc"},  cy, 32'(e.cyc));
  endtask

  // Monitors: pop an expectation whenever a DUT presents done.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (m.done) begin
      if (q_m.size() == 0) begin
        chk("main_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q_m.pop_front();
        cmp_result("main", e, m.sum, m.sum_1hop, m.unplaced_cnt, m.cycles);
`ifdef EVAL_CRITICAL_EN
        chk("main_max_len",  m.max_len,  32'(e.mlen));
        chk("main_max_edge", m.max_edge, 32'(e.medge));
`endif
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (s.done) begin
      if (q_s.size() == 0) begin
        chk("small_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q_s.pop_front();
        cmp_result("small", e, s.sum, s.sum_1hop, s.unplaced_cnt, s.cycles);
`ifdef EVAL_CRITICAL_EN
        chk("small_max_len",  s.max_len,  32'(e.mlen));
        chk("small_max_edge", s.max_edge, 32'(e.medge));
`endif
      end
    end
  end

  // Strobe/address tracker: edge index increments, then source node, then sink node.
  initial begin
    int ee, ph;
    ee = 0;
    ph = 0;
    forever begin
      @(negedge clk);
      if (!m.busy) begin
        ee = 0;
        ph = 0;
      end else begin
        if (m.edge_re && m.pos_re) chk("both_strobes", 32'd1, 32'd0);
        if (m.edge_re) begin
          chk("edge_addr", m.edge_addr, 32'(ee));
          ee++;
          ph = 0;
        end else if (m.pos_re) begin
          if (ee == 0) chk("pos_before_edge", 32'd1, 32'd0);
          else chk(ph == 0 ? "pos_addr_a" : "pos_addr_b", m.pos_addr,
                   32'(ph == 0 ? ea_m[ee - 1] : eb_m[ee - 1]));
          ph++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    bit   seen;
    m.start = 1'b0;
    s.start = 1'b0;
    for (int n = 0; n < 16; n++) begin px_m[n] = 0; py_m[n] = 0; end
    for (int k = 0; k < NE; k++) begin ea_m[k] = 0; eb_m[k] = 0; end
    repeat (3) @(negedge clk);
    chk_zero("reset");
    chk("reset_small_busy", 32'(s.busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-edge worked example: (0,0)-(3,4) and (2,2)-(2,2).
    ea_s = '{0, 2}; eb_s = '{1, 3};
    px_s = '{0, 3, 2, 2}; py_s = '{0, 4, 2, 2};
    @(negedge clk);
    s.start = 1'b1;
    q_s.push_back('{sum: 5, hop: 2, cnt: 0, cyc: 15, mlen: 7, medge: 0});
    @(negedge clk);
    s.start = 1'b0;
    for (int k = 0; k < 100 && q_s.size() != 0; k++) @(negedge clk);
    if (q_s.size() != 0) begin
      chk("small_timeout", 32'd0, 32'd1);
      q_s.delete();
    end

    // Edge lengths 3,9,9,2 then 18 edges touching unplaced node 5; extra start while busy.
    px_m[0] = 0; py_m[0] = 0; px_m[1] = 1; py_m[1] = 2; px_m[2] = 4; py_m[2] = 5;
    px_m[3] = 5; py_m[3] = 4; px_m[4] = 2; py_m[4] = 0; px_m[5] = -1; py_m[5] = -1;
    for (int k = 0; k < NE; k++) begin
      ea_m[k] = (k < 4) ? 0 : 5;
      eb_m[k] = (k < 4) ? k + 1 : 0;
    end
    start_main('{sum: 19, hop: 9, cnt: 18, cyc: 155, mlen: 9, medge: 1});
    repeat (40) @(negedge clk);
    m.start = 1'b1;
    @(negedge clk);
    m.start = 1'b0;
    wait_main("critical");

    // Node 3 unplaced and touched by exactly four edges.
    for (int n = 0; n < 16; n++) begin
      px_m[n] = (n == 3) ? -1 : int'($urandom_range(63));
      py_m[n] = (n == 3) ? -1 : int'($urandom_range(63));
    end
    for (int k = 0; k < NE; k++) begin
      ea_m[k] = int'($urandom_range(14)); if (ea_m[k] >= 3) ea_m[k]++;
      eb_m[k] = int'($urandom_range(14)); if (eb_m[k] >= 3) eb_m[k]++;
    end
    eb_m[2] = 3; ea_m[7] = 3; eb_m[11] = 3; ea_m[19] = 3;
    start_main(model_main());
    wait_main("unplaced");

    for (int r = 0; r < 5; r++) begin
      fill_random(10);
      start_main(model_main());
      wait_main("random");
    end

    // Back-to-back: restart in the cycle after done.
    fill_random(5);
    e = model_main();
    start_main(e);
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (m.done) seen = 1'b1;
    end
    if (!seen) chk("b2b_first_timeout", 32'd0, 32'd1);
    start_main(e);
    wait_main("b2b_second");

    // Abort with reset while edge 5 is being read.
    fill_random(10);
    start_main(model_main());
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (m.edge_re && m.edge_addr == 32'd5) seen = 1'b1;
    end
    if (!seen) chk("abort_edge5_timeout", 32'd0, 32'd1);
    rst_n = 1'b0;
    #1;
    q_m.delete();
    chk_zero("abort");
    repeat (3) @(negedge clk);
    chk_zero("abort_hold");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", 32'(m.done), 0);
    start_main(model_main());
    wait_main("after_abort");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
